// File: rtl/dct_pkg.sv
// -----------------------------------------------------------------------------
// dct_pkg
// Shared definitions for the 1-D/2-D DCT datapath stages.
//   - rounding mode constants (ROUND_TRUNC, ROUND_HALF_UP)
//   - issue FSM state type
//   - clog2() and acc_w() width helpers
//   - sat_to(): clamp a wide signed value to a signed field of a given width
// No ports (package).
// -----------------------------------------------------------------------------
package dct_pkg;

   localparam int ROUND_TRUNC   = 0;  // floor
   localparam int ROUND_HALF_UP = 1;  // add half an LSB, then floor

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } issue_state_t;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) begin
         w++;
      end
      return w;
   endfunction

   // Width of an exact sum of n_in signed dw x cw products.
   function automatic int acc_w(input int dw, input int cw, input int n_in);
      return dw + cw + clog2(n_in);
   endfunction

   // Clamp a signed value to [-2^(width-1), 2^(width-1)-1]; the result is
   // still 64 bits wide and the caller keeps the low 'width' bits.
   function automatic logic signed [63:0] sat_to(input logic signed [63:0] value,
                                                 input int                 width);
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (width - 1));
      if (value > max_v) begin
         return max_v;
      end else if (value < min_v) begin
         return min_v;
      end
      return value;
   endfunction

endpackage

// File: rtl/dct_round_sat.sv
// -----------------------------------------------------------------------------
// dct_round_sat
// Combinational round / arithmetic-shift / saturate of a fixed-point sum.
// The parent registers the result.
//   acc_i  in   IN_W   signed sum with FRAC_BITS fractional bits
//   res_o  out  OUT_W  signed integer result, saturated
// ROUND_MODE: ROUND_TRUNC floors, ROUND_HALF_UP adds 2^(FRAC_BITS-1) first.
// -----------------------------------------------------------------------------
module dct_round_sat
   import dct_pkg::*;
#(
   parameter int IN_W       = 35,
   parameter int FRAC_BITS  = 14,
   parameter int OUT_W      = 16,
   parameter int ROUND_MODE = ROUND_HALF_UP
) (
   input  logic signed [IN_W-1:0]  acc_i,
   output logic signed [OUT_W-1:0] res_o
);

   localparam int RND_SHIFT = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
   localparam logic signed [IN_W:0] RND_C =
      (ROUND_MODE == ROUND_HALF_UP && FRAC_BITS > 0) ? ((IN_W + 1)'(1) <<< RND_SHIFT) : '0;

   // One guard bit so adding the rounding constant can never wrap.
   logic signed [IN_W:0] rnd;
   logic signed [IN_W:0] shifted;
   logic signed [63:0]   wide;

   always_comb begin
      rnd     = {acc_i[IN_W-1], acc_i} + RND_C;
      shifted = rnd >>> FRAC_BITS;
      wide    = {{(63 - IN_W){shifted[IN_W]}}, shifted};
      res_o   = OUT_W'(sat_to(wide, OUT_W));
   end

endmodule

// File: rtl/dct_row_mac_pipe.sv
// -----------------------------------------------------------------------------
// dct_row_mac_pipe
// Pipelined 1-D DCT row stage: accepts one N_IN-sample vector and emits N_OUT
// dot products (one per cycle) against the rows of a coefficient matrix.
//   clk        in   1                       clock
//   reset      in   1                       asynchronous, active-high reset
//   in_valid   in   1                       input vector valid
//   in_ready   out  1                       block can accept a vector
//   in_data    in   DATA_WIDTH*N_IN         sample i at [i*DATA_WIDTH +: DATA_WIDTH]
//   coeff      in   COEFF_WIDTH*N_IN*N_OUT  element (r,i) at [(r*N_IN+i)*COEFF_WIDTH +: COEFF_WIDTH]
//                                           held stable while the block is busy
//   out_valid  out  1                       result valid
//   out_ready  in   1                       downstream accepts result
//   out_data   out  OUT_WIDTH               signed result
//   out_row    out  clog2(N_OUT)            row index of out_data
//   out_last   out  1                       high with row N_OUT-1
// Pipeline: issue -> S1 products -> S2 sum -> S3 round/saturate (out regs).
// A single enable stalls every stage and the issue FSM together.
// -----------------------------------------------------------------------------
module dct_row_mac_pipe
   import dct_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int COEFF_WIDTH = 16,
   parameter int FRAC_BITS   = 14,
   parameter int OUT_WIDTH   = 16,
   parameter int N_IN        = 8,
   parameter int N_OUT       = 8,
   parameter int ROUND_MODE  = ROUND_HALF_UP,
   localparam int ROW_W      = (N_OUT > 1) ? clog2(N_OUT) : 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [DATA_WIDTH*N_IN-1:0]        in_data,
   input  logic [COEFF_WIDTH*N_IN*N_OUT-1:0] coeff,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [OUT_WIDTH-1:0]              out_data,
   output logic [ROW_W-1:0]                  out_row,
   output logic                              out_last
);

   localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;
   localparam int ACC_W  = acc_w(DATA_WIDTH, COEFF_WIDTH, N_IN);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_OUT - 1);

   // ---------------------------------------------------------------- issue FSM
   issue_state_t     state_q, state_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic             load;
   logic             en;
   logic             issue;
   logic             row_is_last;

   logic [DATA_WIDTH*N_IN-1:0] sample_q;

   logic                 s1_valid_q, s2_valid_q, out_valid_q;
   logic [ROW_W-1:0]     s1_row_q, s2_row_q, out_row_q;
   logic                 s1_last_q, s2_last_q, out_last_q;
   logic [OUT_WIDTH-1:0] out_data_q;

   // Output register empty or being drained: everything may advance.
   assign en          = !out_valid_q || out_ready;
   assign issue       = (state_q == ST_RUN) && en;
   assign row_is_last = (row_q == LAST_ROW);
   // Accepting while issuing the last row gives back-to-back vectors.
   assign in_ready    = (state_q == ST_IDLE) || (issue && row_is_last);

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // it unassigned; otherwise synthesis infers a latch.
      state_d = state_q;
      row_d   = row_q;
      load    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               load    = 1'b1;
               row_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (en) begin
               if (row_is_last) begin
                  row_d = '0;
                  if (in_valid) begin
                     load = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  row_d = row_q + ROW_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
      end
   end

   // ------------------------------------------------------- operand unpacking
   logic signed [DATA_WIDTH-1:0]  sample_a [N_IN];
   logic signed [COEFF_WIDTH-1:0] coeff_a  [N_OUT][N_IN];

   always_comb begin
      for (int i = 0; i < N_IN; i++) begin
         sample_a[i] = sample_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
      for (int r = 0; r < N_OUT; r++) begin
         for (int i = 0; i < N_IN; i++) begin
            coeff_a[r][i] = coeff[(r*N_IN + i)*COEFF_WIDTH +: COEFF_WIDTH];
         end
      end
   end

   // ----------------------------------------------------------- S1 / S2 math
   logic signed [PROD_W-1:0] prod_d    [N_IN];
   logic signed [PROD_W-1:0] s1_prod_q [N_IN];
   logic signed [ACC_W-1:0]  acc_d;
   logic signed [ACC_W-1:0]  s2_acc_q;
   logic signed [OUT_WIDTH-1:0] rs_res;

   always_comb begin
      for (int i = 0; i < N_IN; i++) begin
         prod_d[i] = PROD_W'(sample_a[i]) * PROD_W'(coeff_a[row_q][i]);
      end
   end

   always_comb begin
      // NOTE: blocking '=' here is deliberate: each iteration adds onto the
      // partial sum of the previous one, forming a single adder tree.
      acc_d = '0;
      for (int i = 0; i < N_IN; i++) begin
         acc_d = acc_d + ACC_W'(s1_prod_q[i]);
      end
   end

   dct_round_sat #(
      .IN_W       (ACC_W),
      .FRAC_BITS  (FRAC_BITS),
      .OUT_W      (OUT_WIDTH),
      .ROUND_MODE (ROUND_MODE)
   ) u_round_sat (
      .acc_i (s2_acc_q),
      .res_o (rs_res)
   );

   // ------------------------------------------------------ pipeline registers
   // NOTE: sample and datapath registers carry no reset; only the valid bits
   // decide whether their content is meaningful, so resetting them buys nothing.
   always_ff @(posedge clk) begin
      if (load) begin
         sample_q <= in_data;
      end
      if (en) begin
         if (state_q == ST_RUN) begin
            s1_prod_q <= prod_d;
         end
         if (s1_valid_q) begin
            s2_acc_q <= acc_d;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         s1_row_q    <= '0;
         s1_last_q   <= 1'b0;
         s2_valid_q  <= 1'b0;
         s2_row_q    <= '0;
         s2_last_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_row_q   <= '0;
         out_last_q  <= 1'b0;
      end else if (en) begin
         s1_valid_q  <= (state_q == ST_RUN);
         s1_row_q    <= row_q;
         s1_last_q   <= row_is_last;
         s2_valid_q  <= s1_valid_q;
         s2_row_q    <= s1_row_q;
         s2_last_q   <= s1_last_q;
         out_valid_q <= s2_valid_q;
         if (s2_valid_q) begin
            out_data_q <= rs_res;
            out_row_q  <= s2_row_q;
            out_last_q <= s2_last_q;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_row   = out_row_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_dct_row_mac_pipe.sv
// -----------------------------------------------------------------------------
// tb_dct_row_mac_pipe
// Two instances share all inputs: dut_r (ROUND_MODE=1) and dut_t (ROUND_MODE=0).
// Stimulus pushes expected results into one queue per instance; a monitor pops
// and compares on every output transfer and checks hold-stability on stalls.
// -----------------------------------------------------------------------------
module tb_dct_row_mac_pipe;

   typedef struct {
      int data;
      int row;
      bit last;
   } exp_s;

   typedef int vec_t [8];

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          out_ready;
   logic [127:0]  in_data;
   logic [1023:0] coeff;

   logic        ir   [2];
   logic        ov   [2];
   logic        ol   [2];
   logic [15:0] od   [2];
   logic [2:0]  orow [2];

   exp_s q [2][$];

   int n_checks  = 0;
   int n_errors  = 0;
   int cyc       = 0;
   int n_pop     = 0;
   int hs_cyc    = 0;
   int gaps      = 0;
   bit rand_ready = 1'b0;
   bit gap_watch  = 1'b0;

   dct_row_mac_pipe dut_r (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (ir[0]),
      .in_data   (in_data),
      .coeff     (coeff),
      .out_valid (ov[0]),
      .out_ready (out_ready),
      .out_data  (od[0]),
      .out_row   (orow[0]),
      .out_last  (ol[0])
   );

   dct_row_mac_pipe #(.ROUND_MODE(0)) dut_t (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (ir[1]),
      .in_data   (in_data),
      .coeff     (coeff),
      .out_valid (ov[1]),
      .out_ready (out_ready),
      .out_data  (od[1]),
      .out_row   (orow[1]),
      .out_last  (ol[1])
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   // --------------------------------------------------------------- helpers
   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [127:0] pack(input vec_t s);
      logic [127:0] p;
      int v;
      for (int i = 0; i < 8; i++) begin
         v = s[i];
         p[i*16 +: 16] = v[15:0];
      end
      return p;
   endfunction

   task automatic set_c(input int r, input int i, input int v);
      logic [31:0] w;
      w = v;
      coeff[(r*8 + i)*16 +: 16] = w[15:0];
   endtask

   function automatic int model(input logic [127:0] d, input int r, input int rm);
      longint acc;
      acc = 0;
      for (int i = 0; i < 8; i++) begin
         acc += longint'($signed(d[i*16 +: 16])) * longint'($signed(coeff[(r*8 + i)*16 +: 16]));
      end
      if (rm == 1) acc += 8192;
      acc = acc >>> 14;
      if (acc > 32767)  acc = 32767;
      if (acc < -32768) acc = -32768;
      return int'(acc);
   endfunction

   task automatic push(input int k, input int data, input int row);
      exp_s e;
      e.data = data;
      e.row  = row;
      e.last = (row == 7);
      q[k].push_back(e);
   endtask

   task automatic push_rows(input int val_r, input int val_t);
      for (int r = 0; r < 8; r++) begin
         push(0, val_r, r);
         push(1, val_t, r);
      end
   endtask

   task automatic push_model(input logic [127:0] d);
      for (int r = 0; r < 8; r++) begin
         push(0, model(d, r, 1), r);
         push(1, model(d, r, 0), r);
      end
   endtask

   // Offer a vector; returns at posedge+1 of the accepting edge.
   task automatic send(input logic [127:0] d);
      int t;
      t = 0;
      in_data  = d;
      in_valid = 1'b1;
      @(negedge clk);
      while (!ir[0] && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (t >= 400) begin
         check("accept_timeout", t, 0);
         in_valid = 1'b0;
      end else begin
         hs_cyc = cyc;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((q[0].size() != 0 || q[1].size() != 0) && t < 400) begin
         @(negedge clk);
         t++;
      end
      check("drain_within_budget", (t < 400) ? 1 : 0, 1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   // --------------------------------------------------------- out_ready drive
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // ---------------------------------------------------------------- monitor
   initial begin
      bit          stall [2];
      logic [15:0] hd    [2];
      logic [2:0]  hr    [2];
      logic        hl    [2];
      bit          seen;
      exp_s        e;
      stall[0] = 1'b0;
      stall[1] = 1'b0;
      seen     = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            stall[0] = 1'b0;
            stall[1] = 1'b0;
         end else begin
            for (int k = 0; k < 2; k++) begin
               if (stall[k]) begin
                  check("hold_valid", ov[k], 1);
                  check("hold_data", od[k], hd[k]);
                  check("hold_row", orow[k], hr[k]);
                  check("hold_last", ol[k], hl[k]);
               end
               if (ov[k] && out_ready) begin
                  if (q[k].size() == 0) begin
                     n_checks++;
                     n_errors++;
                     $display("FAIL unexpected_out: inst %0d got data %0d row %0d, expected nothing",
                              k, $signed(od[k]), orow[k]);
                  end else begin
                     e = q[k].pop_front();
                     check(k == 0 ? "data_round" : "data_trunc", longint'($signed(od[k])), e.data);
                     check("row", orow[k], e.row);
                     check("last", ol[k], e.last);
                     if (k == 0) n_pop++;
                  end
               end
               stall[k] = ov[k] && !out_ready;
               hd[k] = od[k];
               hr[k] = orow[k];
               hl[k] = ol[k];
            end
         end
         if (gap_watch) begin
            if (ov[0]) seen = 1'b1;
            else if (seen && q[0].size() > 0) gaps++;
         end else begin
            seen = 1'b0;
         end
      end
   end

   // --------------------------------------------------------------- stimulus
   initial begin
      vec_t   id_v;
      vec_t   v1, v2, v3;
      int     t;
      int     base;
      id_v = '{100, -200, 300, -400, 500, -600, 700, -32768};
      v1   = '{1000, -2000, 3000, -4000, 5000, -6000, 7000, -8000};
      v2   = '{32767, 32767, -32768, 12345, -1, 0, 77, -12345};
      v3   = '{3, -3, 5, -5, 9, -9, 11, -11};

      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      coeff    = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_in_ready", ir[0], 1);
      check("reset_out_valid", ov[0], 0);
      check("reset_out_data", od[0], 0);
      check("reset_out_row", orow[0], 0);
      check("reset_out_last", ol[0], 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("post_reset_in_ready", ir[0], 1);

      // Identity: outputs equal inputs, first result 4 cycles after handshake.
      for (int r = 0; r < 8; r++) set_c(r, r, 16384);
      send(pack(id_v));
      for (int r = 0; r < 8; r++) begin
         push(0, id_v[r], r);
         push(1, id_v[r], r);
      end
      t = 0;
      @(negedge clk);
      while (!ov[0] && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("first_latency", cyc - hs_cyc, 4);
      drain();

      // Rounding: row = [8192,0,...], sample0 = +/-3.
      coeff = '0;
      for (int r = 0; r < 8; r++) set_c(r, 0, 8192);
      send(pack('{3, 1234, -1234, 1234, -1234, 1234, -1234, 1234}));
      push_rows(2, 1);
      drain();
      send(pack('{-3, 1234, -1234, 1234, -1234, 1234, -1234, 1234}));
      push_rows(-1, -2);
      drain();

      // Saturation: all coefficients 16384.
      for (int r = 0; r < 8; r++)
         for (int i = 0; i < 8; i++) set_c(r, i, 16384);
      send(pack('{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767}));
      push_rows(32767, 32767);
      drain();
      send(pack('{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768}));
      push_rows(-32768, -32768);
      drain();

      // Back-to-back under random backpressure.
      coeff = '0;
      for (int r = 0; r < 8; r++) begin
         set_c(r, r, 16384);
         set_c(r, (r + 1) % 8, -8192);
         set_c(r, (r + 5) % 8, 5000);
      end
      rand_ready = 1'b1;
      base = n_pop;
      send(pack(v1)); push_model(pack(v1));
      send(pack(v2)); push_model(pack(v2));
      send(pack(v3)); push_model(pack(v3));
      drain();
      rand_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("b2b_stall_count", n_pop - base, 24);

      // Back-to-back with out_ready=1: no output gaps.
      gaps      = 0;
      gap_watch = 1'b1;
      base      = n_pop;
      send(pack(v3)); push_model(pack(v3));
      send(pack(v1)); push_model(pack(v1));
      send(pack(v2)); push_model(pack(v2));
      drain();
      gap_watch = 1'b0;
      check("b2b_count", n_pop - base, 24);
      check("b2b_no_gaps", gaps, 0);

      // Reset after 3 results of a vector.
      coeff = '0;
      for (int r = 0; r < 8; r++) set_c(r, r, 16384);
      base = n_pop;
      send(pack(v1)); push_model(pack(v1));
      t = 0;
      while (n_pop < base + 3 && t < 100) begin
         @(negedge clk);
         #1;
         t++;
      end
      check("mid_reset_reached", n_pop - base, 3);
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("mid_reset_out_valid_r", ov[0], 0);
      check("mid_reset_out_valid_t", ov[1], 0);
      q[0].delete();
      q[1].delete();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("mid_reset_in_ready", ir[0], 1);
      check("mid_reset_no_out", ov[0], 0);
      base = n_pop;
      send(pack(v2)); push_model(pack(v2));
      drain();
      check("after_reset_count", n_pop - base, 8);

      check("queues_empty", q[0].size() + q[1].size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dct_row_mac_pipe.md
# dct_row_mac_pipe

Pipelined, parametrised 1-D DCT stage: accepts one N_IN-sample vector over a valid/ready handshake and produces N_OUT dot products, one per cycle, against the rows of a coefficient matrix. Fixed-point products with a selectable rounding mode and saturation to OUT_WIDTH. Sits between the block/row buffer and the transpose buffer of the 2-D DCT datapath, replacing the single-output, truncating 8-tap multiply-add.

## Interface
- DATA_WIDTH, 16: signed input sample width
- COEFF_WIDTH, 16: signed coefficient width
- FRAC_BITS, 14: fractional bits of the coefficients; the product sum is shifted right by this amount
- OUT_WIDTH, 16: signed output width
- N_IN, 8: samples per vector (taps)
- N_OUT, 8: coefficient rows, i.e. outputs per vector
- ROUND_MODE, 1: 0 = truncate (floor), 1 = round half up (add 2^(FRAC_BITS-1), then floor)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept a vector
- in_data  in  DATA_WIDTH*N_IN  samples; sample i at [i*DATA_WIDTH +: DATA_WIDTH]
- coeff  in  COEFF_WIDTH*N_IN*N_OUT  matrix; element (r,i) at [(r*N_IN+i)*COEFF_WIDTH +: COEFF_WIDTH]; must stay stable while the block is not idle
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  OUT_WIDTH  signed result
- out_row  out  clog2(N_OUT)  row index of out_data
- out_last  out  1  high with row N_OUT-1

## Operation
- Issue FSM, states IDLE and RUN. Row counter `row` runs 0..N_OUT-1.
- IDLE: in_ready=1. On in_valid: latch in_data into the sample register, set row=0, go to RUN.
- RUN: each cycle with pipeline enable `en` high, issue row `row` into stage 1 and increment.
- On issuing row N_OUT-1:
  - if in_valid is also high, latch the new vector, set row=0 and stay in RUN (back-to-back, no bubble);
  - otherwise go to IDLE.
- in_ready = (state==IDLE) || (state==RUN && row==N_OUT-1 && en).
- Pipeline:
  - S1 registers the N_IN products sample[i]*coeff[row][i], each DATA_WIDTH+COEFF_WIDTH bits signed.
  - S2 registers the sum, ACC_W = DATA_WIDTH+COEFF_WIDTH+clog2(N_IN) bits; no overflow is possible.
  - S3 applies the rounding constant (ROUND_MODE), performs an arithmetic shift right by FRAC_BITS, saturates to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and registers out_data.
  - Row index and last flag travel with the data through all stages.
- Per-stage valid bits; a bubble carries no data.
- en = !out_valid || out_ready. Global stall: all stages and the issue FSM hold when en=0.
- Reset clears: FSM to IDLE, row=0, all stage valids, out_valid=0, out_data=0, out_row=0, out_last=0. in_ready=1 after reset.
- Reset mid-vector discards the partially issued vector and any in-flight results. No partial output follows reset.

## Timing
- Latency: a row issued at cycle t appears on out_data at t+3 with out_valid=1, provided there is no stall.
- Throughput: one result per cycle; N_OUT cycles per vector; back-to-back vectors sustain 100% output occupancy.
- Handshakes: transfer occurs when valid&&ready at a rising clk edge. out_data, out_row and out_last are held stable while out_valid && !out_ready.
- The input handshake is not combinationally dependent on in_valid. in_ready depends combinationally on out_ready through en.

## Structure
- Shared package `dct_pkg`:
  - ROUND_TRUNC and ROUND_HALF_UP constants;
  - clog2 function;
  - the ACC_W derivation;
  - saturation helper function sat_to(width).
- One sub-module: `dct_round_sat`, a combinational round, shift and saturate stage, reused by later 2-D stages. Its output is registered in the parent.

## Test plan
All scenarios use default parameters.
- Identity: coeff(r,i)=16384 if r==i, else 0; in_data=[100,-200,300,-400,500,-600,700,-32768] -> outputs equal the input in row order 0..7; out_last only on row 7; first out_valid 4 cycles after the accepting edge.
- Rounding: every row = [8192,0,...], sample0 = 3 then -3:
  - ROUND_MODE=1 -> 2 and -1;
  - ROUND_MODE=0 -> 1 and -2.
- Saturation: all coeff 16384.
  - All samples 32767 -> 32767.
  - All samples -32768 -> -32768.
- Back-to-back with backpressure: three vectors offered continuously while out_ready toggles randomly -> 24 results in order, none duplicated or dropped, outputs stable while stalled; with out_ready=1 there are no gaps.
- Reset mid-operation: assert reset after 3 results of a vector -> out_valid=0 immediately, in_ready=1 after release, next vector produces rows 0..7 cleanly.
